// File: rtl/tpram_pkg.sv
// tpram_pkg: access-mode encodings, sequencer states and byte-mask helpers for tpram_lane_wrap.
package tpram_pkg;
    localparam logic [1:0] MODE_FULL = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_BYTE = 2'b10;
    localparam logic [1:0] MODE_RESV = 2'b11;

    typedef enum logic [1:0] {ST_CLEAR, ST_READY, ST_OFF} state_t;

    // Access width in bytes; a DW=16 half lane collapses to a single byte.
    function automatic int acc_bytes(input logic [1:0] mode, input int lane_bytes);
        return (mode == MODE_FULL || mode == MODE_RESV) ? lane_bytes :
               (mode == MODE_BYTE) ? 1 : lane_bytes / 2;
    endfunction

    function automatic int acc_base(input logic [1:0] mode, input int off, input int lane_bytes);
        return (off / acc_bytes(mode, lane_bytes)) * acc_bytes(mode, lane_bytes);
    endfunction

    function automatic logic [15:0] byte_mask(input logic [1:0] mode, input int off, input int lane_bytes);
        return ((16'd1 << acc_bytes(mode, lane_bytes)) - 16'd1) << acc_base(mode, off, lane_bytes);
    endfunction
endpackage

// File: rtl/tpram_core.sv
// tpram_core: DEPTH x W single-clock RAM with per-bit write mask and registered read-first port.
module tpram_core #(
    parameter int W     = 64,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wmask,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/tpram_lane_wrap.sv
// tpram_lane_wrap: DW-lane RAM wrapper with clear sequencer, masked sub-word access and 2-edge read pipeline.
// Define TPRAM_RAW_BYPASS_EN to forward a same-edge write into a colliding read (new data).
module tpram_lane_wrap
    import tpram_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          TPRAM_CLK,
    input  logic          TPRAM_RSTN,
    input  logic          TPRAM_POWERDN,
    input  logic          TPRAM_CLR,
    output logic          TPRAM_BUSY,
    output logic          TPRAM_DROP,
    input  logic          TPRAM_R_EN,
    input  logic [1:0]    TPRAM_R_MODE,
    input  logic [AW-1:0] TPRAM_R_ADDR,
    output logic [DW-1:0] TPRAM_R_DATA,
    output logic          TPRAM_R_VALID,
    output logic [DW-1:0] TPRAM_MATHB_R_DATA,
    input  logic          TPRAM_W_EN,
    input  logic [1:0]    TPRAM_W_MODE,
    input  logic          TPRAM_WDSEL,
    input  logic [AW-1:0] TPRAM_W_ADDR,
    input  logic [DW-1:0] TPRAM_W_DATA,
    input  logic [DW-1:0] TPRAM_MATHB_W_DATA
);
    localparam int LW    = 2 * DW;
    localparam int LB    = LW / 8;
    localparam int OW    = $clog2(LB);
    localparam int IW    = AW - OW;
    localparam int DEPTH = 2 ** IW;

    state_t        state, state_nx;
    logic [IW-1:0] cnt, cnt_nx;

    always_ff @(posedge TPRAM_CLK or negedge TPRAM_RSTN) begin
        if (!TPRAM_RSTN) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (TPRAM_POWERDN) begin
            state_nx = ST_OFF;
        end else if (state == ST_OFF || TPRAM_CLR) begin
            state_nx = ST_CLEAR;
            cnt_nx   = '0;
        end else if (state == ST_CLEAR) begin
            cnt_nx   = cnt + IW'(1);
            state_nx = (cnt == IW'(DEPTH - 1)) ? ST_READY : ST_CLEAR;
        end
    end

    logic acc_ok, r_acc, w_acc, clearing;
    assign acc_ok     = state == ST_READY && !TPRAM_POWERDN && !TPRAM_CLR;
    assign r_acc      = TPRAM_R_EN && acc_ok;
    assign w_acc      = TPRAM_W_EN && acc_ok;
    assign clearing   = state == ST_CLEAR && !TPRAM_POWERDN;
    assign TPRAM_BUSY = state != ST_READY;

    logic [IW-1:0] r_idx, w_idx;
    logic [1:0]    w_mode;
    logic [DW-1:0] w_src;
    logic [LB-1:0] w_bmask;
    logic [LW-1:0] w_bits, w_line;
    assign r_idx   = TPRAM_R_ADDR[AW-1:OW];
    assign w_idx   = TPRAM_W_ADDR[AW-1:OW];
    // The math block always writes a whole lane.
    assign w_mode  = TPRAM_WDSEL ? MODE_FULL : TPRAM_W_MODE;
    assign w_src   = TPRAM_WDSEL ? TPRAM_MATHB_W_DATA : TPRAM_W_DATA;
    assign w_bmask = LB'(byte_mask(w_mode, int'(TPRAM_W_ADDR[OW-1:0]), DW / 8));
    assign w_line  = LW'(w_src) << (8 * acc_base(w_mode, int'(TPRAM_W_ADDR[OW-1:0]), DW / 8));

    for (genvar b = 0; b < LB; b++) begin : g_wbits
        assign w_bits[8*b +: 8] = {8{w_bmask[b]}};
    end

    logic [IW-1:0] core_waddr;
    logic [LW-1:0] core_wmask, core_wdata, core_q;
    assign core_waddr = clearing ? cnt : w_idx;
    assign core_wmask = clearing ? {LW{1'b1}} : w_bits;
    assign core_wdata = clearing ? {LW{1'b0}} : w_line;

    tpram_core #(.W(LW), .DEPTH(DEPTH)) u_core (
        .clk   (TPRAM_CLK),
        .we    (clearing || w_acc),
        .waddr (core_waddr),
        .wmask (core_wmask),
        .wdata (core_wdata),
        .re    (r_acc),
        .raddr (r_idx),
        .rdata (core_q)
    );

    logic          v1;
    logic [1:0]    r_mode1;
    logic [OW-1:0] r_off1;
    logic [LW-1:0] rd_line, rd_shift;
    logic [DW-1:0] rd_keep, rd_val, rd_lane;
    int            r_base, r_size;

`ifdef TPRAM_RAW_BYPASS_EN
    logic          byp1;
    logic [LW-1:0] byp_bits1, byp_line1;

    always_ff @(posedge TPRAM_CLK or negedge TPRAM_RSTN) begin
        if (!TPRAM_RSTN) begin
            byp1      <= 1'b0;
            byp_bits1 <= '0;
            byp_line1 <= '0;
        end else begin
            byp1 <= r_acc && w_acc && r_idx == w_idx;
            if (r_acc && w_acc) begin
                byp_bits1 <= w_bits;
                byp_line1 <= w_line;
            end
        end
    end

    assign rd_line = byp1 ? (core_q & ~byp_bits1) | (byp_line1 & byp_bits1) : core_q;
`else
    assign rd_line = core_q;
`endif

    assign r_size   = acc_bytes(r_mode1, DW / 8);
    assign r_base   = acc_base(r_mode1, int'(r_off1), DW / 8);
    assign rd_shift = rd_line >> (8 * r_base);
    assign rd_val   = rd_shift[DW-1:0] & rd_keep;
    assign rd_lane  = r_off1[OW-1] ? rd_line[LW-1:DW] : rd_line[DW-1:0];

    for (genvar b = 0; b < DW / 8; b++) begin : g_keep
        assign rd_keep[8*b +: 8] = {8{b < r_size}};
    end

    always_ff @(posedge TPRAM_CLK or negedge TPRAM_RSTN) begin
        if (!TPRAM_RSTN) begin
            v1                 <= 1'b0;
            r_mode1            <= MODE_FULL;
            r_off1             <= '0;
            TPRAM_DROP         <= 1'b0;
            TPRAM_R_VALID      <= 1'b0;
            TPRAM_R_DATA       <= '0;
            TPRAM_MATHB_R_DATA <= '0;
        end else begin
            v1            <= r_acc;
            TPRAM_DROP    <= (TPRAM_R_EN || TPRAM_W_EN) && !acc_ok;
            TPRAM_R_VALID <= v1 && !TPRAM_POWERDN;
            if (r_acc) begin
                r_mode1 <= TPRAM_R_MODE;
                r_off1  <= TPRAM_R_ADDR[OW-1:0];
            end
            if (v1 && !TPRAM_POWERDN) begin
                TPRAM_R_DATA       <= rd_val;
                TPRAM_MATHB_R_DATA <= rd_lane;
            end
        end
    end
endmodule

// File: tb/tb_tpram_lane_wrap.sv
// tb_tpram_lane_wrap: directed and random checks of tpram_lane_wrap (DW=32, AW=12) against a byte-addressed model.
module tb_tpram_lane_wrap;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pd = 1'b0, clr = 1'b0;
    logic        ren = 1'b0, wen = 1'b0, wdsel = 1'b0;
    logic [1:0]  rmode = 2'b00, wmode = 2'b00;
    logic [11:0] raddr = '0, waddr = '0;
    logic [31:0] wdata = '0, mwdata = '0;
    logic        busy, drop, rvalid;
    logic [31:0] rdata, mrdata;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    tpram_lane_wrap #(.DW(32), .AW(12)) dut (
        .TPRAM_CLK          (clk),
        .TPRAM_RSTN         (rst_n),
        .TPRAM_POWERDN      (pd),
        .TPRAM_CLR          (clr),
        .TPRAM_BUSY         (busy),
        .TPRAM_DROP         (drop),
        .TPRAM_R_EN         (ren),
        .TPRAM_R_MODE       (rmode),
        .TPRAM_R_ADDR       (raddr),
        .TPRAM_R_DATA       (rdata),
        .TPRAM_R_VALID      (rvalid),
        .TPRAM_MATHB_R_DATA (mrdata),
        .TPRAM_W_EN         (wen),
        .TPRAM_W_MODE       (wmode),
        .TPRAM_WDSEL        (wdsel),
        .TPRAM_W_ADDR       (waddr),
        .TPRAM_W_DATA       (wdata),
        .TPRAM_MATHB_W_DATA (mwdata)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a plain byte array, a busy countdown and a one-deep read pipeline.
    logic [7:0]  mem_b [4096];
    int          busy_cnt;
    logic        off, p_v;
    logic [31:0] p_d, p_m;
    logic        e_busy, e_drop, e_valid;
    logic [31:0] e_rdata, e_mathb;

    function automatic int m_size(input logic [1:0] md);
        return md == 2'b10 ? 1 : md == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a, input int sz);
        logic [31:0] r;
        int base;
        r = '0;
        base = (int'(a) / sz) * sz;
        for (int i = 0; i < sz; i++) r[8*i +: 8] = mem_b[base + i];
        return r;
    endfunction

    function automatic void m_write(input logic [11:0] a, input int sz, input logic [31:0] d);
        int base;
        base = (int'(a) / sz) * sz;
        for (int i = 0; i < sz; i++) mem_b[base + i] = d[8*i +: 8];
    endfunction

    function automatic void m_zero();
        for (int i = 0; i < 4096; i++) mem_b[i] = 8'h00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic rdy;
        if (!rst_n) begin
            m_zero();
            busy_cnt = 512;
            off = 1'b0;
            p_v = 1'b0;
            p_d = '0;
            p_m = '0;
            e_busy = 1'b1;
            e_drop = 1'b0;
            e_valid = 1'b0;
            e_rdata = '0;
            e_mathb = '0;
        end else begin
            rdy = busy_cnt == 0 && !off && !pd && !clr;
            e_drop = (ren || wen) && !rdy;
            e_valid = p_v && !pd;
            if (e_valid) begin
                e_rdata = p_d;
                e_mathb = p_m;
            end
            p_v = ren && rdy;
`ifdef TPRAM_RAW_BYPASS_EN
            if (wen && rdy) m_write(waddr, wdsel ? 4 : m_size(wmode), wdsel ? mwdata : wdata);
`endif
            if (p_v) begin
                p_d = m_read(raddr, m_size(rmode));
                p_m = m_read(raddr, 4);
            end
`ifndef TPRAM_RAW_BYPASS_EN
            if (wen && rdy) m_write(waddr, wdsel ? 4 : m_size(wmode), wdsel ? mwdata : wdata);
`endif
            if (pd) begin
                off = 1'b1;
            end else if (off || clr) begin
                off = 1'b0;
                busy_cnt = 512;
                m_zero();
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            e_busy = off || busy_cnt > 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            chk("drop", {31'd0, drop}, {31'd0, e_drop});
            chk("r_valid", {31'd0, rvalid}, {31'd0, e_valid});
            chk("r_data", rdata, e_rdata);
            chk("mathb_r_data", mrdata, e_mathb);
        end
    end

    task automatic wr(input logic [11:0] a, input logic [1:0] m, input logic sel, input logic [31:0] d, input logic [31:0] md);
        @(posedge clk); #1;
        wen = 1'b1; waddr = a; wmode = m; wdsel = sel; wdata = d; mwdata = md;
        @(posedge clk); #1;
        wen = 1'b0; wdsel = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [1:0] m, input logic [31:0] exp, input string nm);
        int k;
        @(posedge clk); #1;
        ren = 1'b1; raddr = a; rmode = m;
        @(posedge clk); #1;
        ren = 1'b0;
        k = 99;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (rvalid) begin
                k = j;
                break;
            end
        end
        chk({nm, "_latency"}, 32'(k), 32'd1);
        chk(nm, rdata, exp);
    endtask

    task automatic busy_len(output int n);
        n = 0;
        for (int j = 0; j < 2000; j++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    initial begin
        int n;
        int cnt;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_r_valid", {31'd0, rvalid}, 32'd0);
        chk("rst_r_data", rdata, 32'd0);
        chk("rst_mathb", mrdata, 32'd0);
        chk("rst_drop", {31'd0, drop}, 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        busy_len(n);
        chk("init_busy_cycles", 32'(n), 32'd512);
        rd(12'hFFC, 2'b00, 32'h0000_0000, "rd_ffc");

        for (int i = 0; i < 8; i++) wr(12'(i), 2'b10, 1'b0, 32'(17 * (i + 1)), 32'h0);
        rd(12'h004, 2'b00, 32'h8877_6655, "rd_full_004");
        rd(12'h002, 2'b01, 32'h0000_4433, "rd_half_002");
        chk("mathb_002", mrdata, 32'h4433_2211);
        rd(12'h005, 2'b10, 32'h0000_0066, "rd_byte_005");

        wr(12'h00C, 2'b10, 1'b1, 32'h0000_0077, 32'hDEAD_BEEF);
        rd(12'h00C, 2'b00, 32'hDEAD_BEEF, "rd_mathb_wr_00c");
        rd(12'h008, 2'b00, 32'h0000_0000, "rd_008_kept");

        @(posedge clk); #1;
        wen = 1'b1; waddr = 12'h010; wmode = 2'b00; wdata = 32'hCAFE_F00D;
        ren = 1'b1; raddr = 12'h010; rmode = 2'b00;
        @(posedge clk); #1;
        wen = 1'b0; ren = 1'b0;
        repeat (2) @(negedge clk);
        chk("raw_valid", {31'd0, rvalid}, 32'd1);
`ifdef TPRAM_RAW_BYPASS_EN
        chk("raw_same_edge", rdata, 32'hCAFE_F00D);
`else
        chk("raw_same_edge", rdata, 32'h0000_0000);
`endif
        rd(12'h010, 2'b00, 32'hCAFE_F00D, "rd_010_after");

        wr(12'h020, 2'b00, 1'b0, 32'h1234_5678, 32'h0);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wen = 1'b1; waddr = 12'h020; wmode = 2'b00; wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        wen = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (drop) cnt++;
        end
        chk("clr_drop_pulses", 32'(cnt), 32'd1);
        busy_len(n);
        rd(12'h020, 2'b00, 32'h0000_0000, "rd_020_cleared");

        @(posedge clk); #1;
        ren = 1'b1; raddr = 12'h004; rmode = 2'b00;
        @(posedge clk); #1;
        ren = 1'b0; pd = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid) cnt++;
        end
        chk("pd_no_valid", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        pd = 1'b0;
        @(posedge clk);
        busy_len(n);
        chk("pd_busy_cycles", 32'(n), 32'd512);
        rd(12'h004, 2'b00, 32'h0000_0000, "rd_004_pd");
        rd(12'h00C, 2'b00, 32'h0000_0000, "rd_00c_pd");
        rd(12'h010, 2'b00, 32'h0000_0000, "rd_010_pd");

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            ren    = 1'($urandom_range(0, 1));
            wen    = 1'($urandom_range(0, 1));
            rmode  = 2'($urandom_range(0, 3));
            wmode  = 2'($urandom_range(0, 3));
            wdsel  = ($urandom_range(0, 3) == 0);
            raddr  = 12'($urandom_range(0, 63));
            waddr  = 12'($urandom_range(0, 63));
            wdata  = $urandom;
            mwdata = $urandom;
            pd     = ($urandom_range(0, 999) == 0);
            clr    = ($urandom_range(0, 999) == 0);
        end
        @(posedge clk); #1;
        ren = 1'b0; wen = 1'b0; pd = 1'b0; clr = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tpram_lane_wrap.md
# tpram_lane_wrap

Parametrised single-clock two-port RAM wrapper between the eFPGA fabric and the math block. It generalises the lane width and depth, adds a pipelined read with valid strobe, and adds a hardware clear sequencer that zeroes the array after reset, power-up or request. Sub-word accesses are handled by byte-masked writes and zero-extended reads. Dropped accesses are reported.

## Interface
- DW, 32, lane width in bits (16, 32 or 64); the memory line is 2*DW bits.
- AW, 12, byte address width; LB = 2*DW/8 bytes per line; DEPTH = 2^AW / LB lines (512 at default).
- TPRAM_CLK  in  1  single clock, rising edge.
- TPRAM_RSTN  in  1  asynchronous, active-low reset.
- TPRAM_POWERDN  in  1  array power-gate request.
- TPRAM_CLR  in  1  clear request, sampled each edge.
- TPRAM_BUSY  out  1  clear sequence running or powered down.
- TPRAM_DROP  out  1  one-cycle pulse: an access was rejected.
- TPRAM_R_EN  in  1  read request.
- TPRAM_R_MODE  in  2  00 full lane, 01 half lane, 10 byte, 11 treated as full lane.
- TPRAM_R_ADDR  in  AW  read byte address.
- TPRAM_R_DATA  out  DW  fabric read data.
- TPRAM_R_VALID  out  1  read data strobe.
- TPRAM_MATHB_R_DATA  out  DW  full aligned lane; same timing as R_DATA.
- TPRAM_W_EN  in  1  write request.
- TPRAM_W_MODE  in  2  encoding as R_MODE.
- TPRAM_WDSEL  in  1  1 selects TPRAM_MATHB_W_DATA (always full lane).
- TPRAM_W_ADDR  in  AW  write byte address.
- TPRAM_W_DATA, TPRAM_MATHB_W_DATA  in  DW  write data sources.

## Operation
- Line index = ADDR[AW-1:log2(LB)]. Byte offset o = ADDR[log2(LB)-1:0].
- Byte write stores W_DATA[7:0] to byte o. Half write stores [DW/2-1:0] at o aligned down to a half-lane. Full write stores a lane at o aligned down to a lane.
- Writes use a byte mask. Unwritten bytes of the line keep their value.
- When DW=16, half lane equals byte: mode 01 behaves as mode 10.
- Read extraction uses the same alignment as writes. The result is zero-extended to DW.
- TPRAM_MATHB_R_DATA returns the aligned full lane regardless of R_MODE.
- FSM states:
  - CLEAR: counter writes zero to one line per edge. Counter 0 to DEPTH-1, then go to READY.
  - READY: accepts accesses.
  - OFF: entered from any state while POWERDN=1. On POWERDN deassert, go to CLEAR with counter 0.
- Reset enters CLEAR with counter 0.
- TPRAM_CLR in READY or CLEAR goes to CLEAR with counter 0. A clear already running restarts.
- Priority: POWERDN > CLR > access.
- An R_EN or W_EN outside READY is ignored. TPRAM_DROP pulses the next cycle, once per offending edge.
- Reset values:
  - R_DATA = 0, MATHB_R_DATA = 0, R_VALID = 0, DROP = 0.
  - BUSY = 1.
  - Clear counter = 0.

## Timing
- Read latency is 2 edges. R_EN accepted at edge E: array read at E, output registered at E+1. R_VALID is high for the cycle after E+1.
- Reads are fully pipelined, one per cycle. R_DATA holds its last value when R_VALID is low.
- POWERDN suppresses R_VALID for reads still in the pipeline.
- Write commits at the accepting edge.
- Read and write to the same line at the same edge: read returns the old line (read-first), unless the macro below is defined.
- Clear timing:
  - After reset release, lines 0 to DEPTH-1 are zeroed at edges 1 to DEPTH. BUSY falls after edge DEPTH.
  - CLR sampled at edge E: zeroing runs at edges E+1 to E+DEPTH. BUSY is high from after edge E.

## Configuration
- TPRAM_RAW_BYPASS_EN defined: a same-edge same-line read returns the line merged with the masked write bytes (new data). The read-first path is removed.
- Not defined: read-first behaviour, and no forwarding logic.

## Structure
- Package tpram_pkg:
  - mode localparams FULL/HALF/BYTE/RESV.
  - FSM state typedef {CLEAR, READY, OFF}.
  - Helper function computing the byte mask from mode and offset.
- Sub-module tpram_core: DEPTH x 2*DW array with a per-bit write mask and synchronous read port. It is the only storage.
- The wrapper holds the FSM, masking/rotation, the read pipeline and bypass.

## Test plan
DW=32, AW=12, DEPTH=512.
1. Release reset -> BUSY high exactly 512 cycles. A full read of 0xFFC then returns 0x00000000 with R_VALID 2 edges after R_EN.
2. Byte writes 0x11..0x88 to 0x000..0x007 -> full read 0x004 = 0x88776655; half read 0x002 = 0x00004433; byte read 0x005 = 0x00000066; MATHB_R_DATA for 0x002 = 0x44332211.
3. WDSEL=1, MATHB_W_DATA=0xDEADBEEF, W_MODE=10, addr 0x00C -> full read 0x00C = 0xDEADBEEF; 0x008 unchanged.
4. Same edge: write 0xCAFEF00D to 0x010 and read 0x010 (previously 0) -> 0x00000000 without macro, 0xCAFEF00D with TPRAM_RAW_BYPASS_EN.
5. CLR pulse, then W_EN at 0x020 three cycles later -> DROP pulses once; after BUSY falls, 0x020 reads 0.
6. POWERDN raised one cycle after R_EN -> no R_VALID. On release, BUSY is high 512 cycles, then all lines read 0.
